// File: rtl/arc4_prga.sv
// arc4_prga: ARC4 pseudo-random generation stage.
// Reads a scheduled S-array from a 256x8 synchronous RAM, walks i/j, swaps
// S entries and XORs each keystream byte with a length-prefixed ciphertext
// buffer, writing a plaintext buffer with the same layout.
// Build option: define ARC4_PRGA_LEN_COPY_EN to copy the length byte into pt[0].
module arc4_prga (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  s_addr,
    input  logic [7:0]  s_rddata,
    output logic [7:0]  s_wrdata,
    output logic        s_wren,
    output logic [7:0]  ct_addr,
    input  logic [7:0]  ct_rddata,
    output logic [7:0]  pt_addr,
    output logic [7:0]  pt_wrdata,
    output logic        pt_wren
);

    typedef enum logic [3:0] {
        IDLE,
        RD_LEN,
        LD_LEN,
        RD_SI,
        LD_SI,
        RD_SJ,
        LD_SJ,
        WR_SI,
        WR_SJ,
        RD_PAD,
        LD_PAD,
        WR_PT
`ifdef ARC4_PRGA_LEN_COPY_EN
        , WR_LEN
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] i_q, i_d;
    logic [7:0] j_q, j_d;
    logic [7:0] k_q, k_d;
    logic [7:0] len_q, len_d;
    logic [7:0] si_q, si_d;
    logic [7:0] sj_q, sj_d;
    logic [7:0] pad_q, pad_d;

    // The key port only exists so this stage drops into the same socket as
    // the key-scheduling stage; it carries no information here.
    logic key_unused;
    assign key_unused = ^key;

    // State and datapath registers; reset returns to IDLE with everything cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            k_q     <= 8'd0;
            len_q   <= 8'd0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            pad_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            len_q   <= len_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            pad_q   <= pad_d;
        end
    end

    // Next-state logic and Moore-decoded memory strobes, one state per cycle.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        len_d     = len_q;
        si_d      = si_q;
        sj_d      = sj_q;
        pad_d     = pad_q;
        rdy       = 1'b0;
        s_addr    = 8'd0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        ct_addr   = 8'd0;
        pt_addr   = 8'd0;
        pt_wrdata = 8'd0;
        pt_wren   = 1'b0;

        case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    state_d = RD_LEN;
                end
            end
            RD_LEN: begin
                ct_addr = 8'd0;
                state_d = LD_LEN;
            end
            LD_LEN: begin
                len_d = ct_rddata;
`ifdef ARC4_PRGA_LEN_COPY_EN
                state_d = WR_LEN;
`else
                if (ct_rddata == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    k_d     = 8'd1;
                    state_d = RD_SI;
                end
`endif
            end
`ifdef ARC4_PRGA_LEN_COPY_EN
            WR_LEN: begin
                pt_addr   = 8'd0;
                pt_wrdata = len_q;
                pt_wren   = 1'b1;
                if (len_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    k_d     = 8'd1;
                    state_d = RD_SI;
                end
            end
`endif
            RD_SI: begin
                // Address uses the incremented i so the read lands next cycle.
                i_d     = i_q + 8'd1;
                s_addr  = i_q + 8'd1;
                state_d = LD_SI;
            end
            LD_SI: begin
                si_d    = s_rddata;
                j_d     = j_q + s_rddata;
                state_d = RD_SJ;
            end
            RD_SJ: begin
                s_addr  = j_q;
                state_d = LD_SJ;
            end
            LD_SJ: begin
                sj_d    = s_rddata;
                state_d = WR_SI;
            end
            WR_SI: begin
                s_addr   = i_q;
                s_wrdata = sj_q;
                s_wren   = 1'b1;
                state_d  = WR_SJ;
            end
            WR_SJ: begin
                // When i==j this rewrites the same cell with the same value.
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                ct_addr  = k_q;
                state_d  = RD_PAD;
            end
            RD_PAD: begin
                s_addr  = si_q + sj_q;
                ct_addr = k_q;
                state_d = LD_PAD;
            end
            LD_PAD: begin
                pad_d   = s_rddata;
                ct_addr = k_q;
                state_d = WR_PT;
            end
            WR_PT: begin
                ct_addr   = k_q;
                pt_addr   = k_q;
                pt_wrdata = pad_q ^ ct_rddata;
                pt_wren   = 1'b1;
                if (k_q == len_q) begin
                    state_d = IDLE;
                end else begin
                    k_d     = k_q + 8'd1;
                    state_d = RD_SI;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_arc4_prga.sv
// tb_arc4_prga: randomized and directed checks of arc4_prga against a plain
// RC4 keystream model. Honours ARC4_PRGA_LEN_COPY_EN like the design.
module tb_arc4_prga;

`ifdef ARC4_PRGA_LEN_COPY_EN
    localparam int LAT_BASE  = 3;
    localparam int LEN_WRITE = 1;
`else
    localparam int LAT_BASE  = 2;
    localparam int LEN_WRITE = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  s_addr, s_rddata, s_wrdata;
    logic        s_wren;
    logic [7:0]  ct_addr, ct_rddata;
    logic [7:0]  pt_addr, pt_wrdata;
    logic        pt_wren;

    logic [7:0] s_mem  [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_mem [256];
    logic [7:0] s_init [256];
    logic [7:0] ct_init[256];
    logic [7:0] pt_init[256];
    logic       load_req = 1'b0;
    int         s_wr_cnt = 0;
    int         pt_wr_cnt = 0;

    int tests_run = 0;
    int tests_failed = 0;

    arc4_prga dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .rdy      (rdy),
        .key      (key),
        .s_addr   (s_addr),
        .s_rddata (s_rddata),
        .s_wrdata (s_wrdata),
        .s_wren   (s_wren),
        .ct_addr  (ct_addr),
        .ct_rddata(ct_rddata),
        .pt_addr  (pt_addr),
        .pt_wrdata(pt_wrdata),
        .pt_wren  (pt_wren)
    );

    always #5 clk = ~clk;

    // Three synchronous RAMs with one cycle of read latency, plus a bulk loader.
    always @(posedge clk) begin
        if (load_req) begin
            for (int a = 0; a < 256; a++) begin
                s_mem[a]  <= s_init[a];
                ct_mem[a] <= ct_init[a];
                pt_mem[a] <= pt_init[a];
            end
        end else begin
            if (s_wren)  s_mem[s_addr]   <= s_wrdata;
            if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
        end
        s_rddata  <= s_mem[s_addr];
        ct_rddata <= ct_mem[ct_addr];
        if (s_wren)  s_wr_cnt  <= s_wr_cnt + 1;
        if (pt_wren) pt_wr_cnt <= pt_wr_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_identity();
        for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
    endtask

    task automatic set_shuffled();
        logic [7:0] t;
        int r;
        set_identity();
        for (int a = 255; a > 0; a--) begin
            r = int'($urandom_range(0, a));
            t = s_init[a]; s_init[a] = s_init[r]; s_init[r] = t;
        end
    endtask

    task automatic fill_bufs(input int len, input logic [7:0] pt_fill);
        for (int a = 0; a < 256; a++) begin
            ct_init[a] = 8'($urandom);
            pt_init[a] = pt_fill;
        end
        ct_init[0] = 8'(len);
    endtask

    // Load memories, start one run, and compare memories/latency to the model.
    // pulse_en: toggle en high during busy cycles 5..20.
    // rst_at: if nonzero, assert rst at that busy cycle and only check recovery.
    task automatic run(input string tag, input bit pulse_en, input int rst_at);
        logic [7:0] sr[256];
        logic [7:0] pr[256];
        logic [7:0] i, j, t, len;
        int lat, s_cnt0, pt_cnt0;
        bit aborted;

        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;

        // Reference: textbook RC4 PRGA over plain arrays.
        for (int a = 0; a < 256; a++) begin
            sr[a] = s_init[a];
            pr[a] = pt_init[a];
        end
        len = ct_init[0];
        if (LEN_WRITE == 1) pr[0] = len;
        i = 8'd0;
        j = 8'd0;
        for (int k = 1; k <= int'(len); k++) begin
            i = i + 8'd1;
            j = j + sr[i];
            t = sr[i]; sr[i] = sr[j]; sr[j] = t;
            pr[k] = sr[8'(sr[i] + sr[j])] ^ ct_init[k];
        end

        s_cnt0  = s_wr_cnt;
        pt_cnt0 = pt_wr_cnt;
        key = 24'($urandom);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check_eq({tag, "_rdy_drop"}, 32'(rdy), 32'd0);

        lat = 0;
        aborted = 1'b0;
        while (rdy !== 1'b1 && lat < 5000) begin
            if (rst_at > 0 && lat == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_eq({tag, "_rst_rdy"}, 32'(rdy), 32'd1);
                check_eq({tag, "_rst_s_wren"}, 32'(s_wren), 32'd0);
                check_eq({tag, "_rst_pt_wren"}, 32'(pt_wren), 32'd0);
                aborted = 1'b1;
                break;
            end
            en = pulse_en && lat >= 5 && lat <= 20;
            @(negedge clk);
            lat++;
        end
        en = 1'b0;

        if (!aborted) begin
            check_eq({tag, "_latency"}, 32'(lat), 32'(LAT_BASE + 9 * int'(len)));
            check_eq({tag, "_s_writes"}, 32'(s_wr_cnt - s_cnt0), 32'(2 * int'(len)));
            check_eq({tag, "_pt_writes"}, 32'(pt_wr_cnt - pt_cnt0), 32'(int'(len) + LEN_WRITE));
            for (int a = 0; a < 256; a++) begin
                check_eq($sformatf("%s_pt%0d", tag, a), 32'(pt_mem[a]), 32'(pr[a]));
                check_eq($sformatf("%s_s%0d", tag, a), 32'(s_mem[a]), 32'(sr[a]));
            end
            $display("[TB] %s: L=%0d latency=%0d", tag, len, lat);
        end else begin
            $display("[TB] %s: reset at busy cycle %0d", tag, rst_at);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        key = 24'h0;
        set_identity();
        fill_bufs(0, 8'h00);
        repeat (3) @(negedge clk);
        check_eq("rst_rdy", 32'(rdy), 32'd1);
        check_eq("rst_s_wren", 32'(s_wren), 32'd0);
        check_eq("rst_pt_wren", 32'(pt_wren), 32'd0);
        check_eq("rst_s_addr", 32'(s_addr), 32'd0);
        check_eq("rst_s_wrdata", 32'(s_wrdata), 32'd0);
        check_eq("rst_ct_addr", 32'(ct_addr), 32'd0);
        check_eq("rst_pt_addr", 32'(pt_addr), 32'd0);
        check_eq("rst_pt_wrdata", 32'(pt_wrdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_rdy", 32'(rdy), 32'd1);

        // Identity S, one zero byte: keystream byte is 0x02.
        set_identity();
        fill_bufs(1, 8'h55);
        ct_init[1] = 8'h00;
        run("id_l1", 1'b0, 0);
        check_eq("id_l1_pt1", 32'(pt_mem[1]), 32'h02);
        check_eq("id_l1_pt0", 32'(pt_mem[0]), (LEN_WRITE == 1) ? 32'h01 : 32'h55);
        check_eq("id_l1_s1", 32'(s_mem[1]), 32'h01);

        // Identity S, two 0xAA bytes.
        set_identity();
        fill_bufs(2, 8'h00);
        ct_init[1] = 8'hAA;
        ct_init[2] = 8'hAA;
        run("id_l2", 1'b0, 0);
        check_eq("id_l2_pt1", 32'(pt_mem[1]), 32'hA8);
        check_eq("id_l2_pt2", 32'(pt_mem[2]), 32'hAF);
        check_eq("id_l2_s2", 32'(s_mem[2]), 32'h03);
        check_eq("id_l2_s3", 32'(s_mem[3]), 32'h02);

        // Empty buffer.
        set_identity();
        fill_bufs(0, 8'h77);
        run("len0", 1'b0, 0);

        // en hammered while busy must not disturb the run.
        set_identity();
        fill_bufs(2, 8'h00);
        ct_init[1] = 8'hAA;
        ct_init[2] = 8'hAA;
        run("en_busy", 1'b1, 0);

        // Reset mid-run, then a clean restart on identity S.
        set_identity();
        fill_bufs(2, 8'h00);
        ct_init[1] = 8'hAA;
        ct_init[2] = 8'hAA;
        run("rst_mid", 1'b0, 7);
        set_identity();
        fill_bufs(2, 8'h00);
        ct_init[1] = 8'hAA;
        ct_init[2] = 8'hAA;
        run("after_rst", 1'b0, 0);
        check_eq("after_rst_pt1", 32'(pt_mem[1]), 32'hA8);
        check_eq("after_rst_pt2", 32'(pt_mem[2]), 32'hAF);

        // Random permutations and lengths.
        for (int n = 0; n < 8; n++) begin
            set_shuffled();
            fill_bufs(int'($urandom_range(0, 40)), 8'($urandom));
            run($sformatf("rand%0d", n), 1'b0, 0);
        end

        // Maximum length: k must reach 255 and stop without wrapping.
        set_shuffled();
        fill_bufs(255, 8'h00);
        run("len255", 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
